// File: rtl/requant_int32_uint8.sv
// requant_int32_uint8: 3-stage int32 -> uint8 requantizer (bias add, fixed-point scale, rounding shift, zero point, clamp).
// Defining REQUANT_SAT_CNT_EN adds sat_count, a saturating 16-bit count of clamped output handshakes.
module requant_int32_uint8 #(
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        acc_in,
    input  logic [31:0]        bias_in,
    input  logic [MULT_W-1:0]  mult_in,
    input  logic [SHIFT_W-1:0] shift_in,
    input  logic [7:0]         zero_point,
    input  logic [7:0]         act_min,
    input  logic [7:0]         act_max,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_sat
`ifdef REQUANT_SAT_CNT_EN
    ,
    output logic [15:0]        sat_count
`endif
);
    localparam int PROD_W = 32 + MULT_W;
    localparam int EXT_W  = PROD_W + 1;

    logic                     w_adv;
    logic signed [32:0]       w_sum33;
    logic        [31:0]       w_sum32;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [EXT_W-1:0]  w_prodExt;
    logic signed [EXT_W-1:0]  w_half;
    logic signed [EXT_W-1:0]  w_r;
    logic signed [EXT_W-1:0]  w_v;
    logic signed [EXT_W-1:0]  w_zpExt;
    logic signed [EXT_W-1:0]  w_minExt;
    logic signed [EXT_W-1:0]  w_maxExt;
    logic        [7:0]        w_res;
    logic                     w_satNext;

    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic        [31:0]       r_sum1;
    logic        [MULT_W-1:0] r_mult1;
    logic       [SHIFT_W-1:0] r_shift1;
    logic       [SHIFT_W-1:0] r_shift2;
    logic signed [PROD_W-1:0] r_prod2;
    logic        [7:0]        r_data;
    logic                     r_sat;

    // The whole pipe moves in lockstep; bubbles are kept, so only the output stall can block it.
    assign w_adv     = out_ready | ~r_v3;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out_data  = r_data;
    assign out_sat   = r_sat;

    assign w_sum33 = $signed({acc_in[31], acc_in}) + $signed({bias_in[31], bias_in});

    always_comb begin
        w_sum32 = w_sum33[31:0];
        if (w_sum33[32] != w_sum33[31]) begin
            w_sum32 = w_sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    assign w_prod = $signed({{MULT_W{r_sum1[31]}}, r_sum1}) * $signed({32'd0, r_mult1});

    // One guard bit above the product keeps the rounding add from overflowing.
    assign w_prodExt = {r_prod2[PROD_W-1], r_prod2};

    always_comb begin
        w_half = '0;
        if (r_shift2 != '0) begin
            w_half[r_shift2 - SHIFT_W'(1)] = 1'b1;
        end
    end

    assign w_r      = (w_prodExt + w_half) >>> r_shift2;
    assign w_zpExt  = $signed({{(EXT_W-8){1'b0}}, zero_point});
    assign w_minExt = $signed({{(EXT_W-8){1'b0}}, act_min});
    assign w_maxExt = $signed({{(EXT_W-8){1'b0}}, act_max});
    assign w_v      = w_r + w_zpExt;

    // Lower clamp first, then upper; an inverted range therefore always lands on act_max.
    always_comb begin
        w_res = w_v[7:0];
        if (w_v < w_minExt) begin
            w_res = act_min;
            if (act_min > act_max) begin
                w_res = act_max;
            end
        end else if (w_v > w_maxExt) begin
            w_res = act_max;
        end
        w_satNext = (w_v != $signed({{(EXT_W-8){1'b0}}, w_res}));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_sum1   <= '0;
            r_mult1  <= '0;
            r_shift1 <= '0;
            r_shift2 <= '0;
            r_prod2  <= '0;
            r_data   <= '0;
            r_sat    <= 1'b0;
        end else if (w_adv) begin
            r_v1     <= in_valid;
            r_sum1   <= w_sum32;
            r_mult1  <= mult_in;
            r_shift1 <= shift_in;
            r_v2     <= r_v1;
            r_prod2  <= w_prod;
            r_shift2 <= r_shift1;
            r_v3     <= r_v2;
            r_data   <= w_res;
            r_sat    <= w_satNext;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] r_satCnt;

    // Counts clamped results as they are consumed downstream, sticking at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_satCnt <= '0;
        end else if (r_v3 && out_ready && r_sat && (r_satCnt != 16'hFFFF)) begin
            r_satCnt <= r_satCnt + 16'd1;
        end
    end

    assign sat_count = r_satCnt;
`endif

endmodule

// File: tb/tb_requant_int32_uint8.sv
// Self-checking bench for requant_int32_uint8: directed vector table, latency/throughput/stall/reset sequences,
// and randomized traffic scored against an arithmetic reference model (sat_count checked when REQUANT_SAT_CNT_EN is set).
module tb_requant_int32_uint8;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] acc_in;
    logic [31:0] bias_in;
    logic [15:0] mult_in;
    logic [4:0]  shift_in;
    logic [7:0]  zero_point;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [31:0] acc;
        logic [31:0] bias;
        logic [15:0] mult;
        logic [4:0]  shift;
        logic [7:0]  zp;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [7:0]  expData;
        logic        expSat;
    } vec_t;

    int          compared   = 0;
    int          mismatched = 0;
    int          outCount   = 0;
    exp_t        expQ[$];
    exp_t        monExp;
    logic [15:0] satModel;
    logic        stallValid;
    logic [7:0]  stallData;
    logic        stallSat;
    vec_t        vecs[16];

    always #5 clock = ~clock;

    requant_int32_uint8 dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_in     (acc_in),
        .bias_in    (bias_in),
        .mult_in    (mult_in),
        .shift_in   (shift_in),
        .zero_point (zero_point),
        .act_min    (act_min),
        .act_max    (act_max),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
`ifdef REQUANT_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    // Plain 64-bit arithmetic: saturating bias add, exact product, floor((p + 2^(s-1)) / 2^s), offset, clamp.
    function automatic exp_t refModel(input logic [31:0] acc, input logic [31:0] bias, input logic [15:0] mult,
                                      input logic [4:0] shift, input logic [7:0] zp, input logic [7:0] mn,
                                      input logic [7:0] mx);
        longint s;
        longint p;
        longint r;
        longint v;
        longint res;
        longint d;
        exp_t   e;
        s = longint'($signed(acc)) + longint'($signed(bias));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        p = s * longint'(mult);
        if (shift == 5'd0) begin
            r = p;
        end else begin
            d = longint'(1) << shift;
            r = (p + d / 2) >>> shift;
        end
        v   = r + longint'(zp);
        res = v;
        if (res < longint'(mn)) res = longint'(mn);
        if (res > longint'(mx)) res = longint'(mx);
        e.data = res[7:0];
        e.sat  = (res != v);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveItem(input logic [31:0] acc, input logic [31:0] bias, input logic [15:0] mult,
                             input logic [4:0] shift);
        in_valid = 1'b1;
        acc_in   = acc;
        bias_in  = bias;
        mult_in  = mult;
        shift_in = shift;
    endtask

    task automatic drain();
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Single item into an empty pipe: nothing after edges k and k+1, result after edge k+2.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clock);
        #1;
        zero_point = v.zp;
        act_min    = v.mn;
        act_max    = v.mx;
        driveItem(v.acc, v.bias, v.mult, v.shift);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        checkOutput($sformatf("vec%0d_lat_k", idx), 32'(out_valid), 32'd0);
        @(negedge clock);
        checkOutput($sformatf("vec%0d_lat_k1", idx), 32'(out_valid), 32'd0);
        @(negedge clock);
        checkOutput($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
        checkOutput($sformatf("vec%0d_data", idx), 32'(out_data), 32'(v.expData));
        checkOutput($sformatf("vec%0d_sat", idx), 32'(out_sat), 32'(v.expSat));
    endtask

    // Scoreboard: predicts on every accept, retires on every output handshake, and watches stall hold.
    always @(negedge clock) begin
        if (reset) begin
            expQ.delete();
            satModel   = 16'd0;
            stallValid = 1'b0;
        end else begin
            checkOutput("ready_rule", 32'(in_ready), 32'(out_ready || !out_valid));
`ifdef REQUANT_SAT_CNT_EN
            checkOutput("sat_count", 32'(sat_count), 32'(satModel));
`endif
            if (stallValid) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", 32'(out_data), 32'(stallData));
                checkOutput("stall_sat", 32'(out_sat), 32'(stallSat));
            end
            stallValid = out_valid && !out_ready;
            stallData  = out_data;
            stallSat   = out_sat;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("sb_data", 32'(out_data), 32'(monExp.data));
                    checkOutput("sb_sat", 32'(out_sat), 32'(monExp.sat));
                    outCount++;
                    if (monExp.sat && satModel != 16'hFFFF) satModel = satModel + 16'd1;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(acc_in, bias_in, mult_in, shift_in, zero_point, act_min, act_max));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int idx;
        int startOut;
        int stallLeft;
        bit stalled;

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        acc_in     = '0;
        bias_in    = '0;
        mult_in    = '0;
        shift_in   = '0;
        zero_point = '0;
        act_min    = '0;
        act_max    = 8'd255;

        vecs[0]  = '{32'd100,        32'd28,         16'd32768, 5'd16, 8'd0,  8'd0,   8'd255, 8'd64,  1'b0};
        vecs[1]  = '{32'd3,          32'd0,          16'd1,     5'd1,  8'd0,  8'd0,   8'd255, 8'd2,   1'b0};
        vecs[2]  = '{32'hFFFF_FFFD,  32'd0,          16'd1,     5'd1,  8'd10, 8'd0,   8'd255, 8'd9,   1'b0};
        vecs[3]  = '{32'hFFFF_FE0C,  32'd0,          16'd1,     5'd0,  8'd0,  8'd0,   8'd255, 8'd0,   1'b1};
        vecs[4]  = '{32'd1000,       32'd0,          16'd1,     5'd0,  8'd0,  8'd0,   8'd200, 8'd200, 1'b1};
        vecs[5]  = '{32'h7FFF_FFF0,  32'h0000_0100,  16'd1,     5'd31, 8'd0,  8'd0,   8'd255, 8'd1,   1'b0};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  16'd1,     5'd0,  8'd0,  8'd0,   8'd255, 8'd0,   1'b1};
        vecs[7]  = '{32'd50,         32'd0,          16'd1,     5'd0,  8'd0,  8'd100, 8'd80,  8'd80,  1'b1};
        vecs[8]  = '{32'd200,        32'd0,          16'd1,     5'd0,  8'd0,  8'd100, 8'd80,  8'd80,  1'b1};
        vecs[9]  = '{32'h7FFF_FFFF,  32'd0,          16'hFFFF,  5'd31, 8'd0,  8'd0,   8'd255, 8'd255, 1'b1};
        vecs[10] = '{32'd20,         32'd0,          16'd1,     5'd0,  8'd0,  8'd20,  8'd255, 8'd20,  1'b0};
        vecs[11] = '{32'd200,        32'd0,          16'd1,     5'd0,  8'd0,  8'd0,   8'd200, 8'd200, 1'b0};
        vecs[12] = '{32'hFFFF_FFFB,  32'd0,          16'd1,     5'd2,  8'd10, 8'd0,   8'd255, 8'd9,   1'b0};
        vecs[13] = '{32'd10,         32'd5,          16'd3,     5'd0,  8'd5,  8'd0,   8'd255, 8'd50,  1'b0};
        vecs[14] = '{32'd6,          32'd0,          16'd1,     5'd2,  8'd0,  8'd0,   8'd255, 8'd2,   1'b0};
        vecs[15] = '{32'hFFFF_FFFA,  32'd0,          16'd1,     5'd2,  8'd3,  8'd0,   8'd255, 8'd2,   1'b0};

        // Reset state, then the first cycle out of reset.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef REQUANT_SAT_CNT_EN
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 16; i++) begin
`ifdef REQUANT_SAT_CNT_EN
            if (i == 5) begin
                @(negedge clock);
                checkOutput("sat_count_after_rounding", 32'(sat_count), 32'd2);
            end
`endif
            applyStimulus(vecs[i], i);
        end

        // Throughput: eight back-to-back items, outputs on eight consecutive cycles starting after edge k+2.
        drain();
        zero_point = 8'd0;
        act_min    = 8'd0;
        act_max    = 8'd255;
        driveItem(32'd0, 32'd0, 16'd1, 5'd8);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (c + 1 < 8) driveItem(32'((c + 1) * 256), 32'd0, 16'd1, 5'd8);
            else in_valid = 1'b0;
            @(negedge clock);
            if (c + 1 < 8) checkOutput($sformatf("tp_in_ready%0d", c), 32'(in_ready), 32'd1);
            if (c >= 2) begin
                checkOutput($sformatf("tp_valid%0d", c - 2), 32'(out_valid), 32'd1);
                checkOutput($sformatf("tp_data%0d", c - 2), 32'(out_data), 32'(c - 2));
            end
        end

        // Backpressure: out_ready low for four cycles after the second output.
        drain();
        startOut  = outCount;
        idx       = 0;
        stallLeft = 0;
        stalled   = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clock);
            #1;
            if (idx < 6) driveItem(32'((idx + 10) * 256), 32'd0, 16'd1, 5'd8);
            else in_valid = 1'b0;
            if (!stalled && (outCount - startOut) >= 2) begin
                stalled   = 1'b1;
                stallLeft = 4;
            end
            out_ready = (stallLeft == 0);
            @(negedge clock);
            if (stallLeft > 0) begin
                checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_stall_in_ready", 32'(in_ready), 32'd0);
                stallLeft--;
            end
            if (in_valid && in_ready) idx++;
            if (idx == 6 && (outCount - startOut) == 6) break;
        end
        checkOutput("bp_stalled", 32'(stalled), 32'd1);
        checkOutput("bp_out_count", 32'(outCount - startOut), 32'd6);

        // Reset with three items in flight: nothing may emerge afterwards.
        drain();
        driveItem(32'd1280, 32'd0, 16'd1, 5'd8);
        @(posedge clock);
        #1;
        driveItem(32'd1536, 32'd0, 16'd1, 5'd8);
        @(posedge clock);
        #1;
        driveItem(32'd1792, 32'd0, 16'd1, 5'd8);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef REQUANT_SAT_CNT_EN
        checkOutput("midrst_sat_count", 32'(sat_count), 32'd0);
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput($sformatf("midrst_no_stale%0d", c), 32'(out_valid), 32'd0);
        end

        // Randomized traffic; clamp settings only change once the pipe is empty.
        for (int seg = 0; seg < 3; seg++) begin
            drain();
            zero_point = 8'($urandom());
            act_min    = 8'($urandom_range(100));
            act_max    = 8'($urandom_range(255, 60));
            for (int cyc = 0; cyc < 200; cyc++) begin
                @(posedge clock);
                #1;
                in_valid  = ($urandom_range(3) != 0);
                acc_in    = ($urandom_range(1) != 0) ? 32'($urandom()) : 32'($urandom_range(4000)) - 32'd2000;
                bias_in   = ($urandom_range(7) == 0) ? 32'($urandom()) : 32'($urandom_range(2000)) - 32'd1000;
                mult_in   = 16'($urandom());
                shift_in  = 5'($urandom_range(31));
                out_ready = ($urandom_range(3) != 0);
            end
            drain();
            @(negedge clock);
            checkOutput($sformatf("rand_seg%0d_drained", seg), 32'(expQ.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
